// File: rtl/pueo_command_framer_if.sv
// Handshake bundle for the PUEO command framer: runcmd request, FWU byte stream
// and trigger stream. The DUT side uses the slave modport.
interface pueo_command_framer_if #(
   parameter int TRIG_WIDTH = 15
);
   logic                  runcmd_valid_i;
   logic [1:0]            runcmd_i;
   logic                  runcmd_ready_o;

   logic [7:0]            s_fwu_tdata;
   logic                  s_fwu_tuser;
   logic                  s_fwu_tvalid;
   logic                  s_fwu_tready;

   logic [TRIG_WIDTH-1:0] s_trig_tdata;
   logic                  s_trig_tvalid;
   logic                  s_trig_tready;

   modport master (
      output runcmd_valid_i, runcmd_i,
      output s_fwu_tdata, s_fwu_tuser, s_fwu_tvalid,
      output s_trig_tdata, s_trig_tvalid,
      input  runcmd_ready_o, s_fwu_tready, s_trig_tready
   );

   modport slave (
      input  runcmd_valid_i, runcmd_i,
      input  s_fwu_tdata, s_fwu_tuser, s_fwu_tvalid,
      input  s_trig_tdata, s_trig_tvalid,
      output runcmd_ready_o, s_fwu_tready, s_trig_tready
   );
endinterface

// File: rtl/pueo_command_framer.sv
// Builds one 32-bit command word per command slot (sysclk_phase_i) from a pending
// run command, the FWU byte FIFO head, PPS and the trigger stream, fanned out per link.
module pueo_command_framer #(
   parameter int NUM_LINKS  = 2,
   parameter int FWU_DEPTH  = 16,
   parameter int TRIG_WIDTH = 15
) (
   input  logic                         sysclk_i,
   input  logic                         rst_n_i,
   input  logic                         sysclk_phase_i,
   input  logic                         sysclk_sync_i,
   input  logic                         pps_i,
   pueo_command_framer_if.slave         bus,
   input  logic [NUM_LINKS-1:0]         link_enable_i,
   output logic [32*NUM_LINKS-1:0]      command_o,
   output logic [$clog2(FWU_DEPTH):0]   fwu_count_o
);

   localparam int          AW        = $clog2(FWU_DEPTH);
   localparam int          CW        = AW + 1;
   localparam logic [31:0] IDLE_WORD = 32'h8000_0000;

   logic              alive;
   logic              pending;
   logic [1:0]        pending_cmd;
   logic [8:0]        fifo_mem [FWU_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic              runcmd_ready;
   logic              fwu_ready;
   logic              run_accept;
   logic              fwu_push;
   logic              fwu_pop;
   logic              run_emit;
   logic [8:0]        head;
   logic [14:0]       trig_ext;
   logic [31:0]       word;

   // alive holds the ready outputs low through reset and for the release edge itself
   assign runcmd_ready = alive && !pending;
   assign fwu_ready    = alive && (count < CW'(FWU_DEPTH));

   assign bus.runcmd_ready_o = runcmd_ready;
   assign bus.s_fwu_tready   = fwu_ready;
   assign bus.s_trig_tready  = sysclk_phase_i;

   assign run_accept = bus.runcmd_valid_i && runcmd_ready;
   assign fwu_push   = bus.s_fwu_tvalid && fwu_ready;
   assign fwu_pop    = sysclk_phase_i && (count != '0);
   assign run_emit   = sysclk_phase_i && sysclk_sync_i && pending;
   assign head       = fifo_mem[rd_ptr];

   assign fwu_count_o = count;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      trig_ext                   = '0;
      trig_ext[TRIG_WIDTH-1:0]   = bus.s_trig_tdata;
      word                       = '0;
      word[31]                   = !(run_emit || fwu_pop || pps_i);
      word[30]                   = pps_i;
      if (run_emit) word[27:26]  = pending_cmd;
      if (fwu_pop) begin
         if (head[8]) word[25:16] = {8'b0000_0001, head[0]} << 0 | 10'h002;
         else         word[25:16] = {2'b11, head[7:0]};
      end
      word[15]                   = bus.s_trig_tvalid;
      word[14:0]                 = trig_ext;
   end

   // NOTE: the FIFO storage has no reset; emptiness is defined solely by the pointers/count.
   always_ff @(posedge sysclk_i) begin
      if (fwu_push) fifo_mem[wr_ptr] <= {bus.s_fwu_tuser, bus.s_fwu_tdata};
   end

   always_ff @(posedge sysclk_i) begin
      if (!rst_n_i) begin
         alive       <= 1'b0;
         pending     <= 1'b0;
         pending_cmd <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         command_o   <= {NUM_LINKS{IDLE_WORD}};
      end else begin
         alive <= 1'b1;

         // Acceptance needs !pending, so it can never coincide with emission.
         if (run_emit) begin
            pending <= 1'b0;
         end else if (run_accept) begin
            pending     <= 1'b1;
            pending_cmd <= bus.runcmd_i;
         end

         if (fwu_push) wr_ptr <= wr_ptr + 1'b1;
         if (fwu_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({fwu_push, fwu_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (sysclk_phase_i) begin
            for (int k = 0; k < NUM_LINKS; k++) begin
               command_o[32*k +: 32] <= link_enable_i[k] ? word : IDLE_WORD;
            end
         end
      end
   end

endmodule

// File: tb/tb_pueo_command_framer.sv
// Self-checking bench for pueo_command_framer: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_pueo_command_framer;

   localparam int NL    = 4;
   localparam int DEPTH = 8;
   localparam int TW    = 15;

   logic                   clk     = 1'b0;
   logic                   rst_n   = 1'b0;
   logic                   phase   = 1'b0;
   logic                   sync    = 1'b0;
   logic                   pps     = 1'b0;
   logic [NL-1:0]          link_en = '1;
   logic [32*NL-1:0]       command;
   logic [$clog2(DEPTH):0] fwu_count;

   pueo_command_framer_if #(.TRIG_WIDTH(TW)) bus ();

   pueo_command_framer #(
      .NUM_LINKS (NL),
      .FWU_DEPTH (DEPTH),
      .TRIG_WIDTH(TW)
   ) dut (
      .sysclk_i      (clk),
      .rst_n_i       (rst_n),
      .sysclk_phase_i(phase),
      .sysclk_sync_i (sync),
      .pps_i         (pps),
      .bus           (bus),
      .link_enable_i (link_en),
      .command_o     (command),
      .fwu_count_o   (fwu_count)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state
   logic [8:0]  m_q[$];
   bit          m_alive = 0;
   bit          m_pend  = 0;
   logic [1:0]  m_cmd   = '0;
   logic [31:0] m_word[NL];

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Applies the framer's rules to the inputs present at the coming rising edge.
   task automatic model_edge();
      bit          run_acc, fwu_acc, run_emit, fwu_emit;
      logic [8:0]  e;
      logic [31:0] w;
      if (!rst_n) begin
         m_q.delete();
         m_alive = 0;
         m_pend  = 0;
         foreach (m_word[k]) m_word[k] = 32'h8000_0000;
         return;
      end
      run_acc = bus.runcmd_valid_i && m_alive && !m_pend;
      fwu_acc = bus.s_fwu_tvalid && m_alive && (m_q.size() < DEPTH);
      if (phase) begin
         run_emit = m_pend && sync;
         fwu_emit = m_q.size() > 0;
         w = 32'h0;
         if (!(run_emit || fwu_emit || pps)) w |= 32'h8000_0000;
         if (pps) w |= 32'h4000_0000;
         if (run_emit) begin
            w |= 32'(m_cmd) << 26;
            m_pend = 0;
         end
         if (fwu_emit) begin
            e = m_q.pop_front();
            if (e[8]) w |= (32'h2 | 32'(e[0])) << 16;
            else      w |= (32'h300 | 32'(e[7:0])) << 16;
         end
         if (bus.s_trig_tvalid) w |= 32'h8000;
         w |= 32'(bus.s_trig_tdata);
         foreach (m_word[k]) m_word[k] = link_en[k] ? w : 32'h8000_0000;
      end
      if (run_acc) begin
         m_pend = 1;
         m_cmd  = bus.runcmd_i;
      end
      if (fwu_acc) m_q.push_back({bus.s_fwu_tuser, bus.s_fwu_tdata});
      m_alive = 1;
   endtask

   task automatic cycle(string tag);
      logic [32*NL-1:0] exp_cmd;
      model_edge();
      @(posedge clk);
      #1;
      foreach (m_word[k]) exp_cmd[32*k +: 32] = m_word[k];
      check({tag, ".cmd"},    command,            exp_cmd);
      check({tag, ".count"},  fwu_count,          m_q.size());
      check({tag, ".rready"}, bus.runcmd_ready_o, m_alive && !m_pend);
      check({tag, ".fready"}, bus.s_fwu_tready,   m_alive && (m_q.size() < DEPTH));
      check({tag, ".tready"}, bus.s_trig_tready,  phase);
   endtask

   task automatic push(logic [7:0] data, logic user);
      bus.s_fwu_tvalid = 1'b1;
      bus.s_fwu_tdata  = data;
      bus.s_fwu_tuser  = user;
      cycle("push");
      bus.s_fwu_tvalid = 1'b0;
   endtask

   // One idle cycle followed by one command slot.
   task automatic pulse(string tag, logic with_sync);
      cycle({tag, ".gap"});
      phase = 1'b1;
      sync  = with_sync;
      cycle({tag, ".slot"});
      phase = 1'b0;
      sync  = 1'b0;
   endtask

   initial begin
      bus.runcmd_valid_i = 1'b0;
      bus.runcmd_i       = '0;
      bus.s_fwu_tdata    = '0;
      bus.s_fwu_tuser    = 1'b0;
      bus.s_fwu_tvalid   = 1'b0;
      bus.s_trig_tdata   = '0;
      bus.s_trig_tvalid  = 1'b0;

      // Reset state and release
      repeat (3) cycle("rst");
      check("rst_cmd",   command,                                 {NL{32'h8000_0000}});
      check("rst_ready", {bus.runcmd_ready_o, bus.s_fwu_tready}, 2'b00);
      rst_n = 1'b1;
      cycle("rel");
      check("rel_ready", {bus.runcmd_ready_o, bus.s_fwu_tready}, 2'b11);

      // Run command waits for a phase && sync slot
      bus.runcmd_valid_i = 1'b1;
      bus.runcmd_i       = 2'b10;
      cycle("rc_acc");
      bus.runcmd_valid_i = 1'b0;
      check("rc_busy", bus.runcmd_ready_o, 1'b0);
      pulse("rc_nosync0", 1'b0);
      check("rc_nosync0_f", command[27:26], 2'b00);
      pulse("rc_nosync1", 1'b0);
      check("rc_nosync1_f", command[27:26], 2'b00);
      pulse("rc_sync", 1'b1);
      check("rc_emit",  {command[31], command[27:26]}, 3'b010);
      check("rc_rdy1",  bus.runcmd_ready_o, 1'b1);
      pulse("rc_after", 1'b1);
      check("rc_once",  command[27:26], 2'b00);

      // FWU data byte then mark entry, then empty slot
      push(8'hA5, 1'b0);
      push(8'h01, 1'b1);
      pulse("fwu0", 1'b0);
      check("fwu_data", command[31:16], 16'h03A5);
      pulse("fwu1", 1'b0);
      check("fwu_mark", command[31:16], 16'h0003);
      pulse("fwu2", 1'b0);
      check("fwu_empty", {command[31], command[25:16]}, 11'h400);

      // Fill to depth, then push/pop on the same slot
      bus.s_fwu_tvalid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.s_fwu_tdata = 8'(i * 37 + 5);
         bus.s_fwu_tuser = 1'(i % 3 == 2);
         cycle("fill");
      end
      check("full_ready", bus.s_fwu_tready, 1'b0);
      check("full_count", fwu_count, DEPTH);
      bus.s_fwu_tdata = 8'h77;
      cycle("full_hold");
      check("full_refuse", fwu_count, DEPTH);
      bus.s_fwu_tvalid = 1'b0;
      phase = 1'b1;
      cycle("full_pop");
      phase = 1'b0;
      check("pop_count", fwu_count, DEPTH - 1);
      bus.s_fwu_tvalid = 1'b1;
      bus.s_fwu_tdata  = 8'h5C;
      bus.s_fwu_tuser  = 1'b0;
      phase = 1'b1;
      cycle("pushpop");
      phase = 1'b0;
      bus.s_fwu_tvalid = 1'b0;
      check("pushpop_count", fwu_count, DEPTH - 1);
      repeat (DEPTH) pulse("drain", 1'b0);
      check("drained", fwu_count, 0);

      // Per-link enables with PPS and a trigger in the slot
      link_en            = 4'b0101;
      pps                = 1'b1;
      bus.s_trig_tdata   = 15'h1234;
      bus.s_trig_tvalid  = 1'b1;
      pulse("links", 1'b0);
      check("links_word", command, {32'h8000_0000, 32'h4000_9234, 32'h8000_0000, 32'h4000_9234});
      pps               = 1'b0;
      bus.s_trig_tvalid = 1'b0;
      bus.s_trig_tdata  = '0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         phase              = ($urandom_range(0, 3) == 0);
         sync               = 1'($urandom_range(0, 1));
         pps                = ($urandom_range(0, 4) == 0);
         link_en            = NL'($urandom);
         bus.runcmd_valid_i = ($urandom_range(0, 3) == 0);
         bus.runcmd_i       = 2'($urandom);
         bus.s_fwu_tvalid   = 1'($urandom_range(0, 1));
         bus.s_fwu_tdata    = 8'($urandom);
         bus.s_fwu_tuser    = ($urandom_range(0, 3) == 0);
         bus.s_trig_tvalid  = 1'($urandom_range(0, 1));
         bus.s_trig_tdata   = TW'($urandom);
         cycle("rnd");
      end
      phase = 1'b0; sync = 1'b0; pps = 1'b0; link_en = '1;
      bus.runcmd_valid_i = 1'b0; bus.s_fwu_tvalid = 1'b0;
      bus.s_trig_tvalid  = 1'b0; bus.s_trig_tdata = '0;

      // Reset mid-operation discards FIFO and pending runcmd
      rst_n = 1'b0;
      cycle("rst2");
      rst_n = 1'b1;
      cycle("rel2");
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b1);
      bus.runcmd_valid_i = 1'b1;
      bus.runcmd_i       = 2'b11;
      cycle("rc_acc2");
      bus.runcmd_valid_i = 1'b0;
      check("pre_rst_count", fwu_count, 3);
      check("pre_rst_busy",  bus.runcmd_ready_o, 1'b0);
      rst_n = 1'b0;
      repeat (2) cycle("rst3");
      rst_n = 1'b1;
      cycle("rel3");
      check("rel3_cmd",   command,   {NL{32'h8000_0000}});
      check("rel3_count", fwu_count, 0);
      phase = 1'b1;
      sync  = 1'b1;
      cycle("rel3_slot");
      phase = 1'b0;
      sync  = 1'b0;
      check("rel3_noop", {command[31], command[27:16]}, 13'h1000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
